dmem_bridge: RTL and testbench

DMEM_BRIDGE -- requirements
Module: dmem_bridge

---
 rtl/dbridge_pkg.sv | 23 ++
 rtl/dbridge_addrmap.sv | 25 ++
 rtl/dmem_bridge.sv | 162 ++++++++++++++++
 tb/tb_dmem_bridge.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbridge_pkg.sv
// Shared definitions for the data-memory bridge: FSM encoding, bus size codes
// and the kseg0/kseg1 segment tags used by the address map.
package dbridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [2:0] SEG_KSEG0 = 3'b100;
  localparam logic [2:0] SEG_KSEG1 = 3'b101;

  function automatic logic is_unmapped_seg(input logic [2:0] seg);
    return (seg == SEG_KSEG0) || (seg == SEG_KSEG1);
  endfunction

endpackage

// File: rtl/dbridge_addrmap.sv
// Combinational virtual-to-physical address map and byte-enable to bus size decode.
module dbridge_addrmap
  import dbridge_pkg::*;
(
  input  logic [3:0]  i_sel,
  input  logic [31:0] i_vaddr,
  output logic [1:0]  o_size,
  output logic [31:0] o_paddr
);

  always_comb begin
    o_paddr = i_vaddr;
    if (is_unmapped_seg(i_vaddr[31:29])) o_paddr = {3'b000, i_vaddr[28:0]};
  end

  // Malformed enables fall back to a word access.
  always_comb begin
    unique case (i_sel)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: o_size = SIZE_BYTE;
      4'b0011, 4'b1100:                   o_size = SIZE_HALF;
      default:                            o_size = SIZE_WORD;
    endcase
  end

endmodule

// File: rtl/dmem_bridge.sv
// M-stage load/store to SRAM-like bus bridge with flush cancellation.
// Optional posted-store buffer enabled by defining DBRIDGE_WBUF_EN.
module dmem_bridge
  import dbridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        memenM,
  input  logic        memwriteM,
  input  logic [3:0]  selM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedata2M,
  input  logic        flush_i,
  input  logic        stall_all_i,
  output logic [31:0] readdataM,
  output logic        stall_o,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  state_e      r_state, w_state_nxt;
  logic [31:0] r_rdata_q, r_addr, r_wdata;
  logic [1:0]  r_size;
  logic        r_wr, r_cancel_q;
  logic [31:0] w_paddr;
  logic [1:0]  w_size;
  logic        w_cancel_nxt, w_capture, w_latch, w_can_issue;

  dbridge_addrmap u_addrmap (
    .i_sel   (selM),
    .i_vaddr (aluoutM),
    .o_size  (w_size),
    .o_paddr (w_paddr)
  );

`ifdef DBRIDGE_WBUF_EN
  logic [1:0] r_wr_pending;
  logic       w_wr_inc, w_wr_dec;

  // Loads are only issued with no stores in flight, so a data_ok outside WAIT is a store's.
  assign w_wr_dec    = data_data_ok && (r_wr_pending != 2'd0) && (r_state != ST_WAIT);
  assign w_can_issue = memwriteM ? (r_wr_pending < 2'd2) : (r_wr_pending == 2'd0);

  always_ff @(posedge clk) begin
    if (rst)                        r_wr_pending <= 2'd0;
    else if (w_wr_inc && !w_wr_dec) r_wr_pending <= r_wr_pending + 2'd1;
    else if (!w_wr_inc && w_wr_dec) r_wr_pending <= r_wr_pending - 2'd1;
  end
`else
  assign w_can_issue = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_rdata_q  <= 32'd0;
      r_cancel_q <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_size     <= SIZE_BYTE;
      r_wr       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cancel_q <= w_cancel_nxt;
      if (w_capture) r_rdata_q <= data_rdata;
      if (w_latch) begin
        r_addr  <= w_paddr;
        r_wdata <= writedata2M;
        r_size  <= w_size;
        r_wr    <= memwriteM;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cancel_nxt = r_cancel_q;
    w_capture    = 1'b0;
    w_latch      = 1'b0;
    data_req     = 1'b0;
    data_wr      = memwriteM;
    data_size    = w_size;
    data_addr    = w_paddr;
    data_wdata   = writedata2M;
    stall_o      = 1'b0;
    readdataM    = r_rdata_q;
`ifdef DBRIDGE_WBUF_EN
    w_wr_inc     = 1'b0;
`endif
    if (!rst) begin
      unique case (r_state)
        ST_IDLE: begin
          if (memenM && !flush_i) begin
            stall_o = 1'b1;
            if (w_can_issue) begin
              data_req = 1'b1;
              if (data_addr_ok) begin
`ifdef DBRIDGE_WBUF_EN
                if (memwriteM) begin
                  stall_o  = 1'b0;
                  w_wr_inc = 1'b1;
                end else
`endif
                w_state_nxt = ST_WAIT;
              end else begin
                w_latch     = 1'b1;
                w_state_nxt = ST_REQ;
              end
            end
          end
        end
        ST_REQ: begin
          // Request is frozen from the latched copy; a flush only marks it cancelled.
          data_req   = 1'b1;
          data_wr    = r_wr;
          data_size  = r_size;
          data_addr  = r_addr;
          data_wdata = r_wdata;
          stall_o    = r_cancel_q ? memenM : 1'b1;
          if (flush_i) w_cancel_nxt = 1'b1;
          if (data_addr_ok) begin
`ifdef DBRIDGE_WBUF_EN
            if (r_wr) begin
              stall_o      = 1'b0;
              w_wr_inc     = 1'b1;
              w_cancel_nxt = 1'b0;
              w_state_nxt  = ST_IDLE;
            end else
`endif
            w_state_nxt = ST_WAIT;
          end
        end
        ST_WAIT: begin
          stall_o = r_cancel_q ? memenM : ~data_data_ok;
          if (data_data_ok) begin
            if (r_cancel_q || flush_i) begin
              w_cancel_nxt = 1'b0;
              w_state_nxt  = ST_IDLE;
            end else begin
              readdataM   = data_rdata;
              w_capture   = 1'b1;
              w_state_nxt = stall_all_i ? ST_DONE : ST_IDLE;
            end
          end else if (flush_i) begin
            w_cancel_nxt = 1'b1;
          end
        end
        ST_DONE: begin
          if (!stall_all_i) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge (default build, store buffer disabled).
`timescale 1ns/1ps
module tb_dmem_bridge;

  logic        clk = 1'b0;
  logic        rst, memenM, memwriteM, flush_i, stall_all_i;
  logic [3:0]  selM;
  logic [31:0] aluoutM, writedata2M, data_rdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] readdataM, data_addr, data_wdata;
  logic        stall_o, data_req, data_wr;
  logic [1:0]  data_size;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] q_exp[$];
  logic [31:0] exp_rd;
  logic [31:0] last_rd;

  always #5 clk = ~clk;

  dmem_bridge dut (
    .clk          (clk),
    .rst          (rst),
    .memenM       (memenM),
    .memwriteM    (memwriteM),
    .selM         (selM),
    .aluoutM      (aluoutM),
    .writedata2M  (writedata2M),
    .flush_i      (flush_i),
    .stall_all_i  (stall_all_i),
    .readdataM    (readdataM),
    .stall_o      (stall_o),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata)
  );

  // Inputs change 1ns after the rising edge; outputs are sampled 3ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic quiet();
    memenM = 1'b0; memwriteM = 1'b0; flush_i = 1'b0; stall_all_i = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
    selM = 4'hF; aluoutM = 32'd0; writedata2M = 32'd0;
  endtask

  task automatic test_reset();
    quiet();
    rst = 1'b1; memenM = 1'b1; aluoutM = 32'h8000_0000;
    tick(); tick(); settle();
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b want=0", stall_o); end
    n_checks++; if (data_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b want=0", data_req); end
    n_checks++; if (readdataM !== 32'd0) begin n_fail++; $display("FAIL reset_rdata got=%h want=0", readdataM); end
    rst = 1'b0; memenM = 1'b0;
    tick();
    last_rd = 32'd0;
  endtask

  task automatic test_addrmap();
    logic [31:0] a_in [8];
    logic [31:0] a_exp [8];
    logic [3:0]  s_in [7];
    logic [1:0]  s_exp [7];
    a_in  = '{32'h8000_0010, 32'hA000_0004, 32'hBFFF_FFFC, 32'h9FFF_0000,
              32'hC000_0000, 32'h0000_1234, 32'h6000_0008, 32'hE000_0000};
    a_exp = '{32'h0000_0010, 32'h0000_0004, 32'h1FFF_FFFC, 32'h1FFF_0000,
              32'hC000_0000, 32'h0000_1234, 32'h6000_0008, 32'hE000_0000};
    s_in  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    s_exp = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
    quiet();
    for (int i = 0; i < 8; i++) begin
      aluoutM = a_in[i]; settle();
      n_checks++; if (data_addr !== a_exp[i]) begin n_fail++; $display("FAIL addrmap[%0d] got=%h want=%h", i, data_addr, a_exp[i]); end
      tick();
    end
    for (int i = 0; i < 7; i++) begin
      selM = s_in[i]; settle();
      n_checks++; if (data_size !== s_exp[i]) begin n_fail++; $display("FAIL size_sel%b got=%0d want=%0d", s_in[i], data_size, s_exp[i]); end
      tick();
    end
    quiet();
  endtask

  // Word load, address accepted at once, two empty wait cycles before data.
  task automatic test_load_word();
    int n_stall = 0;
    quiet();
    memenM = 1'b1; aluoutM = 32'h8000_0010; selM = 4'hF; data_addr_ok = 1'b1;
    settle();
    n_stall += int'(stall_o);
    n_checks++; if (data_req !== 1'b1) begin n_fail++; $display("FAIL ld_req got=%b want=1", data_req); end
    n_checks++; if (data_addr !== 32'h0000_0010) begin n_fail++; $display("FAIL ld_addr got=%h want=00000010", data_addr); end
    n_checks++; if (data_size !== 2'd2) begin n_fail++; $display("FAIL ld_size got=%0d want=2", data_size); end
    n_checks++; if (data_wr !== 1'b0) begin n_fail++; $display("FAIL ld_wr got=%b want=0", data_wr); end
    tick();
    data_addr_ok = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      n_stall += int'(stall_o);
      n_checks++; if (data_req !== 1'b0) begin n_fail++; $display("FAIL ld_wait_req%0d got=%b want=0", i, data_req); end
      tick();
    end
    data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF; q_exp.push_back(32'hDEAD_BEEF);
    settle();
    n_stall += int'(stall_o);
    exp_rd = q_exp.pop_front();
    n_checks++; if (readdataM !== exp_rd) begin n_fail++; $display("FAIL ld_data got=%h want=%h", readdataM, exp_rd); end
    tick();
    quiet();
    settle();
    n_checks++; if (readdataM !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ld_hold got=%h want=deadbeef", readdataM); end
    n_checks++; if (n_stall !== 3) begin n_fail++; $display("FAIL ld_stall_cycles got=%0d want=3", n_stall); end
    last_rd = 32'hDEAD_BEEF;
    tick();
  endtask

  // Half store with addr_ok held off three cycles; M inputs perturbed to prove the request is frozen.
  task automatic test_store_half();
    int n_req = 0;
    quiet();
    memenM = 1'b1; memwriteM = 1'b1; selM = 4'b0011; aluoutM = 32'hA000_0004; writedata2M = 32'h0000_5A5A;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin aluoutM = 32'h0000_0FF0; writedata2M = 32'hFFFF_FFFF; selM = 4'hF; end
      if (i == 3) data_addr_ok = 1'b1;
      settle();
      n_req += int'(data_req);
      n_checks++; if (data_addr !== 32'h0000_0004) begin n_fail++; $display("FAIL st_addr%0d got=%h want=00000004", i, data_addr); end
      n_checks++; if (data_size !== 2'd1) begin n_fail++; $display("FAIL st_size%0d got=%0d want=1", i, data_size); end
      n_checks++; if (data_wr !== 1'b1) begin n_fail++; $display("FAIL st_wr%0d got=%b want=1", i, data_wr); end
      n_checks++; if (data_wdata !== 32'h0000_5A5A) begin n_fail++; $display("FAIL st_wdata%0d got=%h want=00005a5a", i, data_wdata); end
      n_checks++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL st_stall%0d got=%b want=1", i, stall_o); end
      tick();
    end
    data_addr_ok = 1'b0; selM = 4'b0011; aluoutM = 32'hA000_0004; writedata2M = 32'h0000_5A5A;
    data_data_ok = 1'b1; data_rdata = 32'd0;
    settle();
    n_req += int'(data_req);
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL st_done_stall got=%b want=0", stall_o); end
    n_checks++; if (n_req !== 4) begin n_fail++; $display("FAIL st_req_cycles got=%0d want=4", n_req); end
    last_rd = 32'd0;
    tick();
    quiet();
  endtask

  task automatic test_stall_all();
    quiet();
    memenM = 1'b1; aluoutM = 32'h0000_2000; data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h1234_5678; stall_all_i = 1'b1;
    q_exp.push_back(32'h1234_5678);
    settle();
    exp_rd = q_exp.pop_front();
    n_checks++; if (readdataM !== exp_rd) begin n_fail++; $display("FAIL sa_data got=%h want=%h", readdataM, exp_rd); end
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL sa_stall got=%b want=0", stall_o); end
    tick();
    data_data_ok = 1'b0; data_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) stall_all_i = 1'b0;
      settle();
      n_checks++; if (readdataM !== exp_rd) begin n_fail++; $display("FAIL sa_hold%0d got=%h want=%h", i, readdataM, exp_rd); end
      n_checks++; if (data_req !== 1'b0) begin n_fail++; $display("FAIL sa_req%0d got=%b want=0", i, data_req); end
      n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL sa_stall%0d got=%b want=0", i, stall_o); end
      tick();
    end
    quiet();
    settle();
    n_checks++; if (data_req !== 1'b0) begin n_fail++; $display("FAIL sa_after_req got=%b want=0", data_req); end
    last_rd = 32'h1234_5678;
    tick();
  endtask

  task automatic test_flush_cancel();
    quiet();
    memenM = 1'b1; aluoutM = 32'h8000_0100; data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0; flush_i = 1'b1;
    tick();
    flush_i = 1'b0; memenM = 1'b1; aluoutM = 32'h0000_0200;
    for (int i = 0; i < 2; i++) begin
      settle();
      n_checks++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL fc_stall%0d got=%b want=1", i, stall_o); end
      n_checks++; if (data_req !== 1'b0) begin n_fail++; $display("FAIL fc_req%0d got=%b want=0", i, data_req); end
      tick();
    end
    data_data_ok = 1'b1; data_rdata = 32'hBAD0_BAD0;
    settle();
    n_checks++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL fc_dok_stall got=%b want=1", stall_o); end
    n_checks++; if (data_req !== 1'b0) begin n_fail++; $display("FAIL fc_dok_req got=%b want=0", data_req); end
    n_checks++; if (readdataM !== last_rd) begin n_fail++; $display("FAIL fc_discard got=%h want=%h", readdataM, last_rd); end
    tick();
    data_data_ok = 1'b0; data_rdata = 32'd0; data_addr_ok = 1'b1;
    settle();
    n_checks++; if (data_req !== 1'b1) begin n_fail++; $display("FAIL fc_new_req got=%b want=1", data_req); end
    n_checks++; if (data_addr !== 32'h0000_0200) begin n_fail++; $display("FAIL fc_new_addr got=%h want=00000200", data_addr); end
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
    q_exp.push_back(32'hCAFE_F00D);
    settle();
    exp_rd = q_exp.pop_front();
    n_checks++; if (readdataM !== exp_rd) begin n_fail++; $display("FAIL fc_data got=%h want=%h", readdataM, exp_rd); end
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL fc_end_stall got=%b want=0", stall_o); end
    last_rd = 32'hCAFE_F00D;
    tick();
    quiet();
  endtask

  task automatic test_flush_idle();
    quiet();
    memenM = 1'b1; flush_i = 1'b1; aluoutM = 32'h0000_0400;
    settle();
    n_checks++; if (data_req !== 1'b0) begin n_fail++; $display("FAIL fi_req got=%b want=0", data_req); end
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL fi_stall got=%b want=0", stall_o); end
    tick();
    quiet();
    settle();
    n_checks++; if (data_req !== 1'b0) begin n_fail++; $display("FAIL fi_after_req got=%b want=0", data_req); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [2];
    vals = '{32'h1111_1111, 32'h2222_2222};
    quiet();
    memenM = 1'b1; aluoutM = 32'h0000_0300; data_addr_ok = 1'b1;
    settle();
    n_checks++; if (data_req !== 1'b1) begin n_fail++; $display("FAIL b2b_req0 got=%b want=1", data_req); end
    tick();
    for (int i = 0; i < 2; i++) begin
      data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = vals[i];
      q_exp.push_back(vals[i]);
      settle();
      exp_rd = q_exp.pop_front();
      n_checks++; if (readdataM !== exp_rd) begin n_fail++; $display("FAIL b2b_data%0d got=%h want=%h", i, readdataM, exp_rd); end
      tick();
      data_data_ok = 1'b0;
      if (i == 0) begin
        aluoutM = 32'h0000_0304; data_addr_ok = 1'b1;
        settle();
        n_checks++; if (data_req !== 1'b1) begin n_fail++; $display("FAIL b2b_req1 got=%b want=1", data_req); end
        n_checks++; if (data_addr !== 32'h0000_0304) begin n_fail++; $display("FAIL b2b_addr1 got=%h want=00000304", data_addr); end
        tick();
      end
    end
    last_rd = 32'h2222_2222;
    quiet();
  endtask

  task automatic test_reset_in_wait();
    quiet();
    memenM = 1'b1; aluoutM = 32'h0000_0500; data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0; rst = 1'b1;
    settle();
    n_checks++; if (data_req !== 1'b0) begin n_fail++; $display("FAIL rw_req_in_rst got=%b want=0", data_req); end
    tick();
    rst = 1'b0; memenM = 1'b0;
    settle();
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL rw_stall got=%b want=0", stall_o); end
    n_checks++; if (data_req !== 1'b0) begin n_fail++; $display("FAIL rw_req got=%b want=0", data_req); end
    n_checks++; if (readdataM !== 32'd0) begin n_fail++; $display("FAIL rw_rdata got=%h want=0", readdataM); end
    tick();
    // A fresh load must issue immediately, which only happens from IDLE.
    memenM = 1'b1; aluoutM = 32'h0000_0600; data_addr_ok = 1'b1;
    settle();
    n_checks++; if (data_req !== 1'b1) begin n_fail++; $display("FAIL rw_idle_req got=%b want=1", data_req); end
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h0BAD_C0DE;
    q_exp.push_back(32'h0BAD_C0DE);
    settle();
    exp_rd = q_exp.pop_front();
    n_checks++; if (readdataM !== exp_rd) begin n_fail++; $display("FAIL rw_data got=%h want=%h", readdataM, exp_rd); end
    tick();
    quiet();
  endtask

  initial begin
    rst = 1'b1;
    quiet();
    test_reset();
    test_addrmap();
    test_load_word();
    test_store_half();
    test_stall_all();
    test_flush_cancel();
    test_flush_idle();
    test_back_to_back();
    test_reset_in_wait();
    n_checks++;
    if (q_exp.size() !== 0) begin n_fail++; $display("FAIL scoreboard_leftover got=%0d want=0", q_exp.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
